// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered WIDTH-bit ALU with valid/ready handshakes on both
//            sides. ADD, complement, DIFF, AND and XOR finish in one cycle.
//            SL/SRL/SRA run on an iterative one-bit-per-cycle shifter.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_in_valid        - request valid
//            o_in_ready        - request can be accepted this cycle
//            i_in1, i_in2      - operand A (flag source), operand B / amount
//            i_alu_control     - opcode (0 ADD,1 NOT,2 SL,3 SRL,4 SRA,
//                                5 DIFF,6 AND,7 XOR)
//            o_out_valid       - result and flags valid
//            i_out_ready       - consumer takes the result
//            o_out             - result
//            o_zero_flag       - in1 == 0 of the accepted request
//            o_msb_flag        - in1[WIDTH-1] of the accepted request
//            o_carry_flag      - carry-out of the most recent accepted ADD
//            o_busy            - a shift is in flight
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  input  logic [2:0]       i_alu_control,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zero_flag,
  output logic             o_msb_flag,
  output logic             o_carry_flag,
  output logic             o_busy
);

  localparam logic [2:0] c_OP_ADD  = 3'd0;
  localparam logic [2:0] c_OP_NOT  = 3'd1;
  localparam logic [2:0] c_OP_SL   = 3'd2;
  localparam logic [2:0] c_OP_SRL  = 3'd3;
  localparam logic [2:0] c_OP_SRA  = 3'd4;
  localparam logic [2:0] c_OP_DIFF = 3'd5;
  localparam logic [2:0] c_OP_AND  = 3'd6;
  localparam logic [2:0] c_OP_XOR  = 3'd7;

  localparam logic [WIDTH-1:0] c_WIDTH_OPND = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] c_WIDTH_CNT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir_left;
  logic               r_fill;
  logic               r_zf_pend;
  logic               r_mf_pend;
  logic [WIDTH-1:0]   r_out;
  logic               r_out_valid;
  logic               r_zf;
  logic               r_mf;
  logic               r_carry;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_shift;
  logic [CNT_W-1:0]   w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_direct;
  logic [WIDTH-1:0]   w_shift_step;
  logic               w_load_shift;
  logic               w_write_direct;
  logic               w_write_shift;

  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || i_out_ready) && !rst;
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_is_shift = (i_alu_control == c_OP_SL) || (i_alu_control == c_OP_SRL) ||
                      (i_alu_control == c_OP_SRA);

  // Amounts of WIDTH or more saturate to WIDTH steps, which already yields
  // all-zero or all-sign results, so no separate saturation path is needed.
  assign w_shamt = (i_in2 >= c_WIDTH_OPND) ? c_WIDTH_CNT : i_in2[CNT_W-1:0];

  assign w_sum = {1'b0, i_in1} + {1'b0, i_in2};

  // r_fill is zero for SRL and the captured sign for SRA.
  assign w_shift_step = r_dir_left ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {r_fill, r_shreg[WIDTH-1:1]};

  // One-cycle results; shifts only reach here with a zero amount.
  always_comb begin
    w_direct = '0;
    case (i_alu_control)
      c_OP_ADD:  w_direct = w_sum[WIDTH-1:0];
      c_OP_NOT:  w_direct = ~i_in1;
      c_OP_SL,
      c_OP_SRL,
      c_OP_SRA:  w_direct = i_in1;
      c_OP_DIFF: w_direct = (i_in1 >= i_in2) ? (i_in1 - i_in2) : (i_in2 - i_in1);
      c_OP_AND:  w_direct = i_in1 & i_in2;
      c_OP_XOR:  w_direct = i_in1 ^ i_in2;
      default:   w_direct = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_load_shift   = 1'b0;
    w_write_direct = 1'b0;
    w_write_shift  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_load_shift = 1'b1;
            w_state_next = S_SHIFT;
          end else begin
            w_write_direct = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        // The final step's shifted value goes straight to the result.
        if (r_cnt == c_CNT_ONE) begin
          w_write_shift = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_dir_left  <= 1'b0;
      r_fill      <= 1'b0;
      r_zf_pend   <= 1'b0;
      r_mf_pend   <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_zf        <= 1'b0;
      r_mf        <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      if (w_load_shift) begin
        r_shreg    <= i_in1;
        r_cnt      <= w_shamt;
        r_dir_left <= (i_alu_control == c_OP_SL);
        r_fill     <= (i_alu_control == c_OP_SRA) && i_in1[WIDTH-1];
        // Flags describe in1 but are published with the result.
        r_zf_pend  <= (i_in1 == '0);
        r_mf_pend  <= i_in1[WIDTH-1];
      end else if (r_state == S_SHIFT) begin
        r_shreg <= w_shift_step;
        r_cnt   <= r_cnt - c_CNT_ONE;
      end

      if (w_write_direct) begin
        r_out <= w_direct;
        r_zf  <= (i_in1 == '0);
        r_mf  <= i_in1[WIDTH-1];
        if (i_alu_control == c_OP_ADD) begin
          r_carry <= w_sum[WIDTH];
        end
      end else if (w_write_shift) begin
        r_out <= w_shift_step;
        r_zf  <= r_zf_pend;
        r_mf  <= r_mf_pend;
      end

      if (w_write_direct || w_write_shift) begin
        r_out_valid <= 1'b1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out        = r_out;
  assign o_zero_flag  = r_zf;
  assign o_msb_flag   = r_mf;
  assign o_carry_flag = r_carry;
  assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq. A transaction-level model
//            predicts handshake, result, flags and latency for the 32-bit
//            instance every cycle; directed literal checks pin the model and
//            exercise an 8-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in1, in2, out;
  logic [2:0]  op;
  logic        zf, mf, cf, busy;

  logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
  logic [7:0]  d8_in1, d8_in2, d8_out;
  logic [2:0]  d8_op;
  logic        d8_zf, d8_mf, d8_cf, d8_busy;

  int n_total = 0;
  int n_bad   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in1(in1), .i_in2(in2), .i_alu_control(op),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out(out), .o_zero_flag(zf), .o_msb_flag(mf),
    .o_carry_flag(cf), .o_busy(busy)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .i_in_valid(d8_in_valid), .o_in_ready(d8_in_ready),
    .i_in1(d8_in1), .i_in2(d8_in2), .i_alu_control(d8_op),
    .o_out_valid(d8_out_valid), .i_out_ready(d8_out_ready),
    .o_out(d8_out), .o_zero_flag(d8_zf), .o_msb_flag(d8_mf),
    .o_carry_flag(d8_cf), .o_busy(d8_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model (32-bit instance) -------------
  // {carry, result} of one operation straight from the arithmetic rules.
  function automatic logic [32:0] mref(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] s;
    case (o)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, ~a};
      3'd2: return (b >= 32) ? 33'd0 : {1'b0, a << b};
      3'd3: return (b >= 32) ? 33'd0 : {1'b0, a >> b};
      3'd4: begin
        if (b >= 32) s = {32{a[31]}};
        else s = 32'($signed(a) >>> b);
        return {1'b0, s};
      end
      3'd5: return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
      3'd6: return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Extra cycles beyond the one-cycle baseline: the saturated shift amount.
  function automatic int mextra(input logic [2:0] o, input logic [31:0] b);
    if (o == 3'd2 || o == 3'd3 || o == 3'd4) return (b >= 32) ? 32 : int'(b);
    return 0;
  endfunction

  int          cyc = 0;
  logic        m_pend = 1'b0;
  int          m_rdy = 0;
  logic [31:0] m_res = '0;
  logic        m_zf = 1'b0, m_mf = 1'b0, m_carry = 1'b0;
  logic        m_vis, m_acc_ok;
  logic [32:0] m_r;

  assign m_vis    = m_pend && (cyc >= m_rdy);
  assign m_acc_ok = !m_pend || (m_vis && out_ready);
  assign m_r      = mref(op, in1, in2);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_pend  <= 1'b0;
      m_carry <= 1'b0;
    end else begin
      if (m_vis && out_ready) m_pend <= 1'b0;
      if (in_valid && m_acc_ok) begin
        m_pend <= 1'b1;
        m_rdy  <= cyc + 1 + mextra(op, in2);
        m_res  <= m_r[31:0];
        m_zf   <= (in1 == 32'd0);
        m_mf   <= in1[31];
        if (op == 3'd0) m_carry <= m_r[32];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_vis});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, !rst && m_acc_ok});
      chk("m_busy", {31'd0, busy}, {31'd0, m_pend && !m_vis});
      chk("m_carry", {31'd0, cf}, {31'd0, m_carry});
      if (m_vis) begin
        chk("m_out", out, m_res);
        chk("m_zero", {31'd0, zf}, {31'd0, m_zf});
        chk("m_msb", {31'd0, mf}, {31'd0, m_mf});
      end
    end
  end

  // ---------------- directed stimulus helpers -----------------------------
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int   k;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 50) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eo, input int elat,
                        output int low);
    int lat;
    send(o, a, b);
    lat = 1;
    low = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 100) break;
      if (!in_ready) low++;
      lat++;
      @(posedge clk); #1;
    end
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_out"}, out, eo);
  endtask

  int low;
  int lat8;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0; out_ready = 1'b1;
    d8_in_valid = 1'b0; d8_op = '0; d8_in1 = '0; d8_in2 = '0; d8_out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_flags", {29'd0, zf, mf, cf}, 32'd0);
    chk("rst_d8_out", {24'd0, d8_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD overflow, then XOR keeps carry
    run_op("add_ovf", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, low);
    chk("add_ovf_carry", {31'd0, cf}, 32'd1);
    chk("add_ovf_zero", {31'd0, zf}, 32'd0);
    chk("add_ovf_msb", {31'd0, mf}, 32'd1);
    run_op("xor", 3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, low);
    chk("xor_carry_held", {31'd0, cf}, 32'd1);

    // Shifts
    run_op("sra4", 3'd4, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, low);
    chk("sra4_ready_low", low, 4);
    run_op("sl40", 3'd2, 32'h1234_5678, 32'd40, 32'h0000_0000, 33, low);
    run_op("srl0", 3'd3, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, 1, low);
    run_op("srl3", 3'd3, 32'h8000_00F0, 32'd3, 32'h1000_001E, 4, low);

    // DIFF and complement
    run_op("diff_5_9", 3'd5, 32'd5, 32'd9, 32'd4, 1, low);
    run_op("diff_9_5", 3'd5, 32'd9, 32'd5, 32'd4, 1, low);
    run_op("diff_7_7", 3'd5, 32'd7, 32'd7, 32'd0, 1, low);
    run_op("not0", 3'd1, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, low);
    chk("not0_zero", {31'd0, zf}, 32'd1);

    // Backpressure: ADD result held while out_ready is low
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; in1 = 32'h8000_0000; in2 = 32'h8000_0000;
    @(posedge clk); #1;
    op = 3'd6; in1 = 32'hF0F0_1234; in2 = 32'h0FF0_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out", out, 32'd0);
      chk("bp_flags", {29'd0, zf, mf, cf}, 32'b011);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_out", out, 32'h00F0_1234);

    // Streaming four ANDs
    begin
      logic [31:0] sa [4];
      logic [31:0] sb [4];
      logic [31:0] se [4];
      sa[0] = 32'hFFFF_0000; sb[0] = 32'h1234_5678; se[0] = 32'h1234_0000;
      sa[1] = 32'h0F0F_0F0F; sb[1] = 32'hFFFF_FFFF; se[1] = 32'h0F0F_0F0F;
      sa[2] = 32'hAAAA_AAAA; sb[2] = 32'h5555_5555; se[2] = 32'h0000_0000;
      sa[3] = 32'hC3C3_C3C3; sb[3] = 32'h0FF0_0FF0; se[3] = 32'h03C0_03C0;
      @(posedge clk); #1;
      in_valid = 1'b1; op = 3'd6; in1 = sa[0]; in2 = sb[0];
      @(posedge clk); #1;
      for (int i = 1; i <= 4; i++) begin
        if (i < 4) begin
          in1 = sa[i]; in2 = sb[i];
        end else begin
          in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_out", out, se[i-1]);
        @(posedge clk); #1;
      end
    end

    // Reset during the second cycle of a 10-bit shift
    send(3'd2, 32'h8000_0001, 32'd10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out", out, 32'd0);
    chk("midrst_flags", {29'd0, zf, mf, cf}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    run_op("add_2_3", 3'd0, 32'd2, 32'd3, 32'd5, 1, low);

    // WIDTH = 8 instance
    @(posedge clk); #1;
    d8_in_valid = 1'b1; d8_op = 3'd0; d8_in1 = 8'hFF; d8_in2 = 8'h02;
    @(negedge clk);
    chk("d8_add_ready", {31'd0, d8_in_ready}, 32'd1);
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    @(negedge clk);
    chk("d8_add_valid", {31'd0, d8_out_valid}, 32'd1);
    chk("d8_add_out", {24'd0, d8_out}, 32'h01);
    chk("d8_add_carry", {31'd0, d8_cf}, 32'd1);
    @(posedge clk); #1;
    d8_in_valid = 1'b1; d8_op = 3'd4; d8_in1 = 8'h90; d8_in2 = 8'd9;
    @(negedge clk);
    chk("d8_sra_ready", {31'd0, d8_in_ready}, 32'd1);
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    lat8 = 1;
    forever begin
      @(negedge clk);
      if (d8_out_valid || lat8 > 50) break;
      lat8++;
      @(posedge clk); #1;
    end
    chk("d8_sra_lat", lat8, 9);
    chk("d8_sra_out", {24'd0, d8_out}, 32'hFF);
    chk("d8_sra_carry_held", {31'd0, d8_cf}, 32'd1);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the single-cycle KGP_RISC ALU, with a valid/ready handshake on both sides. It performs the same eight operations at WIDTH bits. Shifts run on an iterative one-bit-per-cycle shifter instead of a barrel shifter. All other operations complete in one cycle. It sits between the register-read stage and writeback, and stalls upstream through `in_ready` while a shift is in flight or the result has not been taken.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 2.
- `CNT_W`, $clog2(WIDTH+1): width of the internal shift counter (derived; do not override).
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and opcode are valid.
- `in_ready` output 1: the block can accept a request this cycle.
- `in1` input WIDTH: operand A; also the flag source.
- `in2` input WIDTH: operand B, or the shift amount.
- `alu_control` input 3: opcode.
  - 0 ADD
  - 1 complement (~in1)
  - 2 SL
  - 3 SRL
  - 4 SRA
  - 5 DIFF
  - 6 AND
  - 7 XOR
- `out_valid` output 1: result and flags are valid.
- `out_ready` input 1: the consumer takes the result this cycle.
- `out` output WIDTH: result.
- `zero_flag` output 1: in1 == 0, captured at accept.
- `msb_flag` output 1: in1[WIDTH-1], captured at accept.
- `carry_flag` output 1: carry-out of the most recent accepted ADD.
- `busy` output 1: state ≠ IDLE.

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready) && !rst. Back-to-back single-cycle ops therefore stream at one per cycle.
- States:
  - IDLE. On accepting opcode 2/3/4 with n = min(in2, WIDTH) > 0:
    - load the shift register with in1 and the counter with n;
    - go to SHIFT.
  - IDLE, any other accept (including a shift with n == 0): write the result register directly and stay in IDLE.
  - SHIFT. Each cycle, shift by one bit and decrement the counter.
    - SL fills with 0.
    - SRL fills with 0.
    - SRA fills with the original in1[WIDTH-1].
    - When the counter reaches 0, write the result register and return to IDLE.
- Arithmetic:
  - ADD: {carry, out} = in1 + in2 at WIDTH+1 bits; carry-in is 0.
  - DIFF: out = |in1 − in2|, with operands unsigned. in1 == in2 gives 0.
  - Shift amount ≥ WIDTH saturates: SL/SRL give 0, SRA gives all copies of the sign. It costs WIDTH cycles, not in2.
- Flags:
  - `zero_flag` and `msb_flag` describe in1 of the accepted request, not the result. They are written together with `out`.
  - `carry_flag` is written only when an ADD is accepted and holds its value across all other opcodes.
- Output register:
  - `out_valid` is set when a result is written.
  - `out_valid` clears on `out_ready` unless a new result is written in the same cycle.
  - `out` and flags are stable while `out_valid && !out_ready`.
- Reset:
  - state = IDLE.
  - `out`, `zero_flag`, `msb_flag`, `carry_flag` and `out_valid` = 0.
  - The counter and shift register are cleared.
  - A reset mid-shift aborts the operation, and no result is produced.

## Timing
- Single-cycle ops: accepted at edge k, `out_valid` = 1 after edge k+1 (latency 1).
- Shift by n ≥ 1: accepted at edge k, result after edge k+n+1 (latency n+1). `in_ready` is 0 for those n cycles.
- Shift by n = 0: latency 1; `out` = in1.
- Simultaneous `out_ready` and a new accept: the old result is consumed and the new one is visible the next cycle, with no bubble.
- Result stalled (`out_valid && !out_ready`): `in_ready` = 0 and nothing is overwritten.
- `in_ready` is low in the cycle `rst` is high and high in the first cycle after it.

## Test plan
- Reset, then ADD 0xFFFFFFFF + 0x00000001 → `out` = 0, `carry_flag` = 1, `zero_flag` = 0, `msb_flag` = 1, latency 1. A following XOR 0xF0F0F0F0 ^ 0xFF00FF00 → `out` = 0x0FF00FF0, `carry_flag` still 1.
- Shifts:
  - SRA in1 = 0x80000000, in2 = 4 → `out` = 0xF8000000 after 5 cycles, `in_ready` low for 4 cycles.
  - SL in2 = 40 → `out` = 0 after 33 cycles.
  - SRL in2 = 0 → `out` = in1 after 1 cycle.
- DIFF 5 − 9 → 4; DIFF 9 − 5 → 4; DIFF 7 − 7 → 0. Complement 0 → 0xFFFFFFFF with `zero_flag` = 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles with a result pending → `out`/flags constant, `in_ready` = 0. Release → the next request is accepted in the same cycle the result is consumed. Streaming 4 AND ops with `out_ready` = 1 gives 4 results in 4 consecutive cycles.
- Assert `rst` during cycle 2 of a 10-bit shift → no `out_valid`, all outputs 0, `in_ready` = 1 on the next cycle, and a following ADD 2 + 3 → 5.
- WIDTH = 8 instance: ADD 0xFF + 0x02 → `out` = 0x01, carry = 1; SRA 0x90 by 9 → 0xFF after 9 cycles.
